quant_mb_sched: RTL

//  Sequences one macroblock's 4x4 coefficient blocks through the shared 4x4 quantizer.

---
 rtl/quant_pkg.sv | 21 ++
 rtl/quant_mb_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/quant_pkg.sv
// Shared codes for the macroblock quantizer scheduler: matrix selects,
// FSM encodings and block index constants.
package quant_pkg;

  localparam logic [1:0] MTX_Y1 = 2'd0;
  localparam logic [1:0] MTX_Y2 = 2'd1;
  localparam logic [1:0] MTX_UV = 2'd2;

  localparam logic [4:0] IDX_Y2  = 5'd24;
  localparam logic [4:0] IDX_UV0 = 5'd16;
  localparam int         NZ_W    = 25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

endpackage

// File: rtl/quant_mb_sched.sv
// Walks one macroblock's 4x4 blocks (optional Y2, 16 Y, 8 UV) through a shared
// quantizer, forwarding each result downstream and collecting the non-zero mask.
module quant_mb_sched
  import quant_pkg::*;
#(
  parameter int IW      = 16,
  parameter int NBLK_Y  = 16,
  parameter int NBLK_UV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mb_start,
  input  logic             mb_i16,
  output logic             mb_busy,
  output logic             mb_done,
  output logic [NZ_W-1:0]  nz_mask,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [16*IW-1:0] src_data,
  output logic             q_start,
  output logic [16*IW-1:0] q_in,
  output logic [1:0]       q_mtx_sel,
  output logic             q_first,
  input  logic             q_done,
  input  logic             q_nz,
  input  logic [255:0]     q_out,
  input  logic [255:0]     q_rout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_data,
  output logic [255:0]     out_rout,
  output logic [4:0]       out_idx
);

  state_t r_state;
  state_t w_state_next;

  logic [4:0]       r_cnt;
  logic             r_i16;
  logic [NZ_W-1:0]  r_nz;
  logic             r_done;
  logic [16*IW-1:0] r_q_in;
  logic [1:0]       r_mtx;
  logic             r_first;
  logic [255:0]     r_out_data;
  logic [255:0]     r_out_rout;

  logic [4:0] w_idx;
  logic [4:0] w_last_cnt;
  logic       w_last;
  logic [1:0] w_mtx;
  logic       w_first;
  logic       w_accept;
  logic       w_fetch_hs;
  logic       w_capture;
  logic       w_emit_hs;

  // The counter counts blocks in emission order; in i16 mode slot 0 is the Y2 block.
  assign w_idx      = r_i16 ? ((r_cnt == 5'd0) ? IDX_Y2 : r_cnt - 5'd1) : r_cnt;
  assign w_last_cnt = r_i16 ? 5'(NBLK_Y + NBLK_UV) : 5'(NBLK_Y + NBLK_UV - 1);
  assign w_last     = (r_cnt == w_last_cnt);

  always_comb begin
    w_mtx   = MTX_UV;
    w_first = 1'b0;
    if (w_idx == IDX_Y2) begin
      w_mtx = MTX_Y2;
    end else if (w_idx < IDX_UV0) begin
      w_mtx   = MTX_Y1;
      w_first = r_i16;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mb_busy      = 1'b1;
    src_ready    = 1'b0;
    q_start      = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_fetch_hs   = 1'b0;
    w_capture    = 1'b0;
    w_emit_hs    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        mb_busy = 1'b0;
        if (mb_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        src_ready = 1'b1;
        if (src_valid) begin
          w_fetch_hs   = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        q_start      = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (q_done) begin
          w_capture    = 1'b1;
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_emit_hs    = 1'b1;
          w_state_next = w_last ? ST_IDLE : ST_FETCH;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_i16      <= 1'b0;
      r_nz       <= '0;
      r_done     <= 1'b0;
      r_q_in     <= '0;
      r_mtx      <= MTX_Y1;
      r_first    <= 1'b0;
      r_out_data <= '0;
      r_out_rout <= '0;
    end else begin
      r_done <= w_emit_hs & w_last;
      if (w_accept) begin
        r_cnt <= '0;
        r_i16 <= mb_i16;
        r_nz  <= '0;
      end
      if (w_fetch_hs) begin
        r_q_in  <= src_data;
        r_mtx   <= w_mtx;
        r_first <= w_first;
      end
      if (w_capture) begin
        r_out_data  <= q_out;
        r_out_rout  <= q_rout;
        r_nz[w_idx] <= q_nz;
      end
      // The counter stays on the last block after mb_done so out_idx remains meaningful.
      if (w_emit_hs && !w_last) r_cnt <= r_cnt + 5'd1;
    end
  end

  assign mb_done   = r_done;
  assign nz_mask   = r_nz;
  assign q_in      = r_q_in;
  assign q_mtx_sel = r_mtx;
  assign q_first   = r_first;
  assign out_data  = r_out_data;
  assign out_rout  = r_out_rout;
  assign out_idx   = w_idx;

endmodule
